// File: rtl/wn_pdcchrx_pkg.sv
// Shared types, DMRS code points and fixed-point helpers for the PDCCH RX DMRS path.
package wn_pdcchrx_pkg;

  localparam logic [1:0] DMRS_PP = 2'b00;
  localparam logic [1:0] DMRS_NP = 2'b01;
  localparam logic [1:0] DMRS_PN = 2'b10;
  localparam logic [1:0] DMRS_NN = 2'b11;

  typedef enum logic {
    ST_ACC   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  function automatic int acc_w(int iw, int ngrp);
    return iw + 1 + $clog2(ngrp);
  endfunction

  function automatic longint sat(longint x, int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - longint'(1);
    lo = -hi - longint'(1);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Round half up, then arithmetic shift.
  function automatic longint rnd_shr(longint x, int sh);
    if (sh == 0) return x;
    return (x + (longint'(1) <<< (sh - 1))) >>> sh;
  endfunction

endpackage

// File: rtl/wn_pdcchrx_dmrs_prb_combiner_if.sv
// AXI-stream style bundle: data, valid, last, ready.
interface wn_pdcchrx_dmrs_prb_combiner_if #(
  parameter int W = 8
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/wn_pdcchrx_qpsk_derot.sv
// Per-antenna conjugate multiply by a QPSK DMRS symbol, IW -> IW+1 bits.
module wn_pdcchrx_qpsk_derot
  import wn_pdcchrx_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic signed [IW-1:0] a_i,
  input  logic signed [IW-1:0] b_i,
  input  logic [1:0]           code_i,
  output logic signed [IW:0]   i_o,
  output logic signed [IW:0]   q_o
);
  localparam int PW = IW + 1;
  localparam int XW = IW + 2;

  logic signed [XW-1:0] a;
  logic signed [XW-1:0] b;
  logic signed [XW-1:0] pi;
  logic signed [XW-1:0] pq;

  assign a = XW'(a_i);
  assign b = XW'(b_i);

  always_comb begin
    pi = '0;
    pq = '0;
    unique case (1'b1)
      (code_i == DMRS_PP): begin
        pi = a + b;
        pq = b - a;
      end
      (code_i == DMRS_NP): begin
        pi = b - a;
        pq = -a - b;
      end
      (code_i == DMRS_PN): begin
        pi = a - b;
        pq = a + b;
      end
      (code_i == DMRS_NN): begin
        pi = -a - b;
        pq = a - b;
      end
      default: ;
    endcase
  end

  // -(-FS)-(-FS) is the one case that needs clipping back to IW+1.
  assign i_o = PW'(sat(longint'(pi), PW));
  assign q_o = PW'(sat(longint'(pq), PW));

endmodule

// File: rtl/wn_pdcchrx_dmrs_prb_combiner.sv
// PDCCH DMRS modulation removal with optional per-PRB coherent combining.
// Joins the DMRS code and RX sample streams; single registered output stage.
module wn_pdcchrx_dmrs_prb_combiner
  import wn_pdcchrx_pkg::*;
#(
  parameter int nRX       = 2,
  parameter int IW        = 16,
  parameter int OW        = 16,
  parameter int NGRP      = 3,
  parameter int ACC_SHIFT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic mode,
  input  logic err_clr,
  wn_pdcchrx_dmrs_prb_combiner_if.slave  dmrs_in,
  wn_pdcchrx_dmrs_prb_combiner_if.slave  data_in,
  wn_pdcchrx_dmrs_prb_combiner_if.master estm_out,
  output logic short_grp_err
);
  localparam int PW = IW + 1;
  localparam int AW = acc_w(IW, NGRP);
  localparam int CW = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int NC = 2 * nRX;
  localparam int DW = NC * OW;
  localparam logic [CW-1:0] LAST_CNT = CW'(NGRP - 1);

  state_e               st_q, st_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [AW-1:0] acc_q  [NC];
  logic signed [AW-1:0] acc_d  [NC];
  logic signed [AW-1:0] acc_nx [NC];
  logic signed [PW-1:0] prod   [NC];
  logic                 mode_q, mode_d;
  logic [DW-1:0]        od_q, od_d, res;
  logic                 ov_q, ov_d;
  logic                 ol_q, ol_d;
  logic                 err_q, err_d;
  logic                 mode_eff, last_re, done;
  logic                 both_v, can_take, take;
  logic                 unused_w;

  for (genvar k = 0; k < nRX; k++) begin : g_derot
    wn_pdcchrx_qpsk_derot #(.IW(IW)) u_derot (
      .a_i    (data_in.tdata[2*k*IW +: IW]),
      .b_i    (data_in.tdata[(2*k+1)*IW +: IW]),
      .code_i (dmrs_in.tdata[1:0]),
      .i_o    (prod[2*k]),
      .q_o    (prod[2*k+1])
    );
  end

  // Mode is latched on the first RE of a group only.
  always_comb begin
    mode_eff = (cnt_q == '0) ? mode : mode_q;
    last_re  = (cnt_q == LAST_CNT);
    done     = !mode_eff || last_re || data_in.tlast;
    both_v   = data_in.tvalid && dmrs_in.tvalid;
  end

  always_comb begin
    res = '0;
    for (int c = 0; c < NC; c++) begin
      acc_nx[c] = acc_q[c] + AW'(prod[c]);
      if (mode_eff)
        res[c*OW +: OW] =
          OW'(sat(rnd_shr(longint'(acc_nx[c]), ACC_SHIFT), OW));
      else
        res[c*OW +: OW] =
          OW'(sat(longint'(prod[c]) >>> 1, OW));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) st_q <= ST_ACC;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_ACC:
        if (both_v && done && ov_q && !estm_out.tready)
          st_d = ST_DRAIN;
      ST_DRAIN:
        if (estm_out.tready)
          st_d = ST_ACC;
      default: st_d = ST_ACC;
    endcase
  end

  always_comb begin
    can_take = (st_q == ST_ACC) &&
               (!done || !ov_q || estm_out.tready);
    take     = both_v && can_take;
  end

  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    od_d   = od_q;
    ov_d   = ov_q && !estm_out.tready;
    ol_d   = ol_q;
    err_d  = err_q && !err_clr;
    for (int c = 0; c < NC; c++) acc_d[c] = acc_q[c];
    if (take) begin
      mode_d = mode_eff;
      if (done) begin
        cnt_d = '0;
        for (int c = 0; c < NC; c++) acc_d[c] = '0;
        od_d  = res;
        ov_d  = 1'b1;
        ol_d  = data_in.tlast;
        if (mode_eff && data_in.tlast && !last_re)
          err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
        for (int c = 0; c < NC; c++) acc_d[c] = acc_nx[c];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
      od_q   <= '0;
      ov_q   <= 1'b0;
      ol_q   <= 1'b0;
      err_q  <= 1'b0;
      for (int c = 0; c < NC; c++) acc_q[c] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      od_q   <= od_d;
      ov_q   <= ov_d;
      ol_q   <= ol_d;
      err_q  <= err_d;
      for (int c = 0; c < NC; c++) acc_q[c] <= acc_d[c];
    end
  end

  assign data_in.tready  = can_take;
  assign dmrs_in.tready  = can_take;
  assign estm_out.tdata  = od_q;
  assign estm_out.tvalid = ov_q;
  assign estm_out.tlast  = ol_q;
  assign short_grp_err   = err_q;
  assign unused_w        = ^{dmrs_in.tdata[7:2], dmrs_in.tlast};

endmodule

// File: tb/tb_wn_pdcchrx_dmrs_prb_combiner.sv
// Directed-table and random-handshake bench for the DMRS PRB combiner.
// Antenna 1 always carries antenna 0's sample with I and Q swapped.
module tb_wn_pdcchrx_dmrs_prb_combiner;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic mode = 1'b0;
  logic err_clr = 1'b0;
  logic short_grp_err;

  always #5 clock = ~clock;

  wn_pdcchrx_dmrs_prb_combiner_if #(.W(8))  dmrs_if ();
  wn_pdcchrx_dmrs_prb_combiner_if #(.W(64)) data_if ();
  wn_pdcchrx_dmrs_prb_combiner_if #(.W(64)) estm_if ();

  wn_pdcchrx_dmrs_prb_combiner #(
    .nRX(2), .IW(16), .OW(16), .NGRP(3), .ACC_SHIFT(2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mode          (mode),
    .err_clr       (err_clr),
    .dmrs_in       (dmrs_if),
    .data_in       (data_if),
    .estm_out      (estm_if),
    .short_grp_err (short_grp_err)
  );

  typedef struct {
    logic [63:0] d;
    logic        l;
  } exp_t;

  typedef struct {
    logic        md;
    logic [1:0]  code;
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
    logic        emit;
    logic [15:0] i0, q0, i1, q1;
    logic        elast;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t mon_e;
  logic rnd_rdy = 1'b0;
  logic pv = 1'b0;
  logic [63:0] pd;
  logic pl;

  longint m_acc[4];
  int     m_cnt = 0;
  bit     m_mode = 1'b0;

  always @(posedge clock) cyc++;

  always @(posedge clock) begin
    #1;
    estm_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clock) begin
    if (reset) begin
      pv = 1'b0;
    end else begin
      if (pv) begin
        checks++;
        if (!estm_if.tvalid || estm_if.tdata !== pd || estm_if.tlast !== pl) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                   estm_if.tvalid, estm_if.tdata, estm_if.tlast, pd, pl);
        end
      end
      if (estm_if.tvalid && estm_if.tready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL extra_output: data=%h last=%b required none",
                   estm_if.tdata, estm_if.tlast);
        end else begin
          mon_e = q.pop_front();
          if (estm_if.tdata !== mon_e.d || estm_if.tlast !== mon_e.l) begin
            errors++;
            $display("FAIL output: data=%h last=%b required data=%h last=%b",
                     estm_if.tdata, estm_if.tlast, mon_e.d, mon_e.l);
          end
        end
      end
      pv = estm_if.tvalid && !estm_if.tready;
      pd = estm_if.tdata;
      pl = estm_if.tlast;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic send(input logic md, input logic [1:0] code,
                      input logic [15:0] a0, input logic [15:0] b0,
                      input logic [15:0] a1, input logic [15:0] b1,
                      input logic last, input bit rnd);
    int n;
    bit dfirst;
    mode = md;
    dmrs_if.tdata = {6'b101101, code};
    dmrs_if.tlast = 1'b0;
    data_if.tdata = {b1, a1, b0, a0};
    data_if.tlast = last;
    dfirst = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    if (dfirst) data_if.tvalid = 1'b1;
    else        dmrs_if.tvalid = 1'b1;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
    end
    data_if.tvalid = 1'b1;
    dmrs_if.tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clock);
      if (data_if.tready && dmrs_if.tready) break;
      n++;
      if (n > 200) begin
        errors++;
        $display("FAIL accept_timeout: got no tready in %0d cycles required accept", n);
        break;
      end
    end
    @(posedge clock);
    #1;
    data_if.tvalid = 1'b0;
    dmrs_if.tvalid = 1'b0;
  endtask

  function automatic longint clip(longint x, int w);
    longint hi;
    hi = (longint'(1) <<< (w - 1)) - 1;
    if (x > hi) return hi;
    if (x < -hi - 1) return -hi - 1;
    return x;
  endfunction

  task automatic model_beat(input logic md, input logic [1:0] code,
                            input logic [15:0] a0, input logic [15:0] b0,
                            input logic [15:0] a1, input logic [15:0] b1,
                            input logic last, output bit emit,
                            output logic [63:0] d);
    longint a[2];
    longint b[2];
    longint p[4];
    longint v[4];
    a[0] = longint'($signed(a0));
    b[0] = longint'($signed(b0));
    a[1] = longint'($signed(a1));
    b[1] = longint'($signed(b1));
    if (m_cnt == 0) m_mode = md;
    for (int k = 0; k < 2; k++) begin
      case (code)
        2'b00: begin p[2*k] = a[k] + b[k]; p[2*k+1] = b[k] - a[k]; end
        2'b01: begin p[2*k] = b[k] - a[k]; p[2*k+1] = -a[k] - b[k]; end
        2'b10: begin p[2*k] = a[k] - b[k]; p[2*k+1] = a[k] + b[k]; end
        default: begin p[2*k] = -a[k] - b[k]; p[2*k+1] = a[k] - b[k]; end
      endcase
    end
    emit = 1'b0;
    for (int c = 0; c < 4; c++) begin
      p[c] = clip(p[c], 17);
      v[c] = clip(p[c] >>> 1, 16);
    end
    if (!m_mode) begin
      emit = 1'b1;
    end else begin
      for (int c = 0; c < 4; c++) m_acc[c] += p[c];
      if (m_cnt == 2 || last) begin
        emit = 1'b1;
        for (int c = 0; c < 4; c++) begin
          v[c] = clip((m_acc[c] + 2) >>> 2, 16);
          m_acc[c] = 0;
        end
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    d = {v[3][15:0], v[2][15:0], v[1][15:0], v[0][15:0]};
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clock);
      n++;
    end
    @(negedge clock);
    chk(nm, 64'(q.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[20];
    int c0;
    bit em;
    logic [63:0] ed;
    logic md;
    logic [1:0] cd;
    logic [15:0] ra, rb;
    logic rl;

    tv[0]  = '{0, 2'b00, 16'h4000, 16'h2000, 0, 1, 16'h3000, 16'hF000, 16'h3000, 16'h1000, 0};
    tv[1]  = '{0, 2'b01, 16'h4000, 16'h2000, 0, 1, 16'hF000, 16'hD000, 16'h1000, 16'hD000, 0};
    tv[2]  = '{0, 2'b10, 16'h4000, 16'h2000, 0, 1, 16'h1000, 16'h3000, 16'hF000, 16'h3000, 0};
    tv[3]  = '{0, 2'b11, 16'h4000, 16'h2000, 1, 1, 16'hD000, 16'h1000, 16'hD000, 16'hF000, 1};
    tv[4]  = '{0, 2'b11, 16'h8000, 16'h8000, 0, 1, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 0};
    tv[5]  = '{1, 2'b00, 16'h4000, 16'h0000, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0};
    tv[6]  = '{1, 2'b00, 16'h4000, 16'h0000, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0};
    tv[7]  = '{1, 2'b00, 16'h4000, 16'h0000, 0, 1, 16'h3000, 16'hD000, 16'h3000, 16'h3000, 0};
    tv[8]  = '{1, 2'b00, 16'h4000, 16'h0000, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0};
    tv[9]  = '{1, 2'b00, 16'h4000, 16'h0000, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0};
    tv[10] = '{1, 2'b00, 16'h4000, 16'h0000, 1, 1, 16'h3000, 16'hD000, 16'h3000, 16'h3000, 1};
    tv[11] = '{1, 2'b00, 16'h7FFF, 16'h7FFF, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0};
    tv[12] = '{1, 2'b00, 16'h7FFF, 16'h7FFF, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0};
    tv[13] = '{1, 2'b00, 16'h7FFF, 16'h7FFF, 0, 1, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 0};
    tv[14] = '{1, 2'b00, 16'h0002, 16'h0000, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0};
    tv[15] = '{1, 2'b00, 16'h0002, 16'h0000, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0};
    tv[16] = '{1, 2'b00, 16'h0002, 16'h0000, 0, 1, 16'h0002, 16'hFFFF, 16'h0002, 16'h0002, 0};
    tv[17] = '{1, 2'b11, 16'h1000, 16'h1000, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0};
    tv[18] = '{1, 2'b11, 16'h1000, 16'h1000, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0};
    tv[19] = '{1, 2'b11, 16'h1000, 16'h1000, 0, 1, 16'hE800, 16'h0000, 16'hE800, 16'h0000, 0};

    data_if.tvalid = 1'b0;
    data_if.tlast  = 1'b0;
    data_if.tdata  = '0;
    dmrs_if.tvalid = 1'b0;
    dmrs_if.tlast  = 1'b0;
    dmrs_if.tdata  = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_tvalid", 64'(estm_if.tvalid), 64'd0);
    chk("rst_tlast", 64'(estm_if.tlast), 64'd0);
    chk("rst_tdata", estm_if.tdata, 64'd0);
    chk("rst_err", 64'(short_grp_err), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    c0 = cyc;
    for (int i = 0; i < 20; i++) begin
      send(tv[i].md, tv[i].code, tv[i].a, tv[i].b, tv[i].b, tv[i].a,
           tv[i].last, 1'b0);
      if (tv[i].emit)
        q.push_back('{{tv[i].q1, tv[i].i1, tv[i].q0, tv[i].i0}, tv[i].elast});
    end
    chk("throughput_cycles", 64'(cyc - c0), 64'd20);
    drain("table_drained");
    chk("no_err_full_groups", 64'(short_grp_err), 64'd0);

    send(1, 2'b00, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 0, 1'b0);
    send(1, 2'b00, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 1, 1'b0);
    q.push_back('{{16'h2000, 16'h2000, 16'hE000, 16'h2000}, 1'b1});
    @(negedge clock);
    chk("short_err_set", 64'(short_grp_err), 64'd1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("short_err_sticky", 64'(short_grp_err), 64'd1);
    @(posedge clock);
    #1;
    err_clr = 1'b1;
    @(posedge clock);
    #1;
    err_clr = 1'b0;
    @(negedge clock);
    chk("short_err_clr", 64'(short_grp_err), 64'd0);
    @(posedge clock);
    #1;

    send(1, 2'b00, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 0, 1'b0);
    err_clr = 1'b1;
    send(1, 2'b00, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 1, 1'b0);
    err_clr = 1'b0;
    q.push_back('{{16'h2000, 16'h2000, 16'hE000, 16'h2000}, 1'b1});
    @(negedge clock);
    chk("err_set_wins", 64'(short_grp_err), 64'd1);
    drain("short_drained");

    send(1, 2'b00, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 0, 1'b0);
    send(1, 2'b00, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 0, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midgrp_rst_tvalid", 64'(estm_if.tvalid), 64'd0);
    chk("midgrp_rst_tdata", estm_if.tdata, 64'd0);
    chk("midgrp_rst_err", 64'(short_grp_err), 64'd0);
    @(posedge clock);
    #1;
    send(1, 2'b00, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 0, 1'b0);
    send(0, 2'b00, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 0, 1'b0);
    send(0, 2'b00, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 1, 1'b0);
    q.push_back('{{16'h3000, 16'h3000, 16'hD000, 16'h3000}, 1'b1});
    drain("fresh_group_drained");
    chk("fresh_group_err", 64'(short_grp_err), 64'd0);

    for (int c = 0; c < 4; c++) m_acc[c] = 0;
    m_cnt = 0;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      md = 1'($urandom_range(0, 1));
      cd = 2'($urandom_range(0, 3));
      ra = rnd16();
      rb = rnd16();
      rl = (i == 999) || ($urandom_range(0, 5) == 0);
      send(md, cd, ra, rb, rb, ra, rl, 1'b1);
      model_beat(md, cd, ra, rb, rb, ra, rl, em, ed);
      if (em) q.push_back('{ed, rl});
    end
    rnd_rdy = 1'b0;
    drain("random_drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
